except_redirect: RTL and testbench
==================================

# except_redirect

Exception/ERET redirect controller sitting directly downstream of the CP0 block in the dual-issue MIPS pipeline. It consumes CP0's flush request, target PC and issuing-slot flags. It then produces per-stage flush signals, a slot-2 kill, and a held PC-redirect request that stays up until the fetch stage accepts it. Before redirecting, it waits for any outstanding data-memory transaction to drain.

## Interface
Parameters:
- RESET_PC, 32'hbfc00000, value held on redirect_pc after reset.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  reset, synchronous, active-high.
- to_be_flushed  input  1  CP0 flush request: exception or ERET this cycle.
- new_pc  input  32  CP0 target PC, valid when to_be_flushed=1.
- caused_by_i1  input  1  event belongs to issue slot 1.
- caused_by_i2  input  1  event belongs to issue slot 2.
- stallreq_mem  input  1  data bus transaction outstanding; must not be abandoned.
- fetch_ready  input  1  IF stage accepts a redirect this cycle.
- flush  output  4  per-stage flush: bit0 IF, bit1 ID, bit2 EX, bit3 MEM/WB latch.
- kill_i2  output  1  suppress slot-2 writeback of the current bundle.
- redirect_valid  output  1  redirect request pending.
- redirect_pc  output  32  target PC for IF.
- busy  output  1  controller not IDLE.
- exc_count  output  32  redirect count (see Configuration).

## Operation
- States: IDLE, DRAIN, REDIRECT. Encoding is free; the reset state is IDLE.
- Event: in IDLE, the cycle with to_be_flushed=1.
- In the event cycle (Mealy, combinational):
  - flush[2:0]=3'b111 and flush[3]=0.
  - kill_i2 = caused_by_i1. When the slot-1 instruction faults, its slot-2 partner never commits. When only slot 2 faults, slot 1 commits.
  - redirect_pc_q <= new_pc.
  - Next state is DRAIN if stallreq_mem=1, otherwise REDIRECT.
- DRAIN:
  - flush=4'b1111, kill_i2=0, redirect_valid=0.
  - Leaves for REDIRECT in the first cycle with stallreq_mem=0.
- REDIRECT:
  - flush=4'b1111 and redirect_valid=1.
  - Returns to IDLE at the clock edge where fetch_ready=1.
- IDLE with no event: flush=0, kill_i2=0, redirect_valid=0.
- redirect_pc = redirect_pc_q (registered).
- busy = (state != IDLE).
- to_be_flushed while busy is ignored. The first latched PC wins, and redirect_pc_q does not change.
- caused_by_i1 and caused_by_i2 both 1: treat as slot-1 event, so kill_i2=1.
- to_be_flushed=1 with neither slot flag set (ERET, interrupt): kill_i2=0.
- caused_by_* are ignored when to_be_flushed=0.

## Timing
- Reset values:
  - state IDLE.
  - flush 0, kill_i2 0, redirect_valid 0, busy 0.
  - redirect_pc RESET_PC.
  - exc_count 0.
- Reset mid-operation: returns to IDLE on the next edge with rst=1 and drops any pending redirect.
- No-drain latency, event at cycle T:
  - redirect_valid=1 and redirect_pc=new_pc(T) at T+1.
  - If fetch_ready=1 at T+1, IDLE at T+2, so busy is high exactly 1 cycle.
- With drain: if stallreq_mem stays high through T..T+k, REDIRECT is entered at T+k+2.
- Handshake:
  - redirect_valid and redirect_pc stay stable until a cycle with fetch_ready=1.
  - fetch_ready while not in REDIRECT has no effect.
- The earliest new event is accepted in the IDLE cycle after the handshake completes.

## Configuration
- REDIRECT_CNT_EN defined:
  - exc_count is a 32-bit register, incremented at each event (IDLE with to_be_flushed=1).
  - Wraps from 32'hffffffff to 0.
  - Cleared by rst.
- Not defined: exc_count is tied to 32'b0 and no counter flop is built.

## Test plan
- Slot-1 fault, no drain:
  - Stimulus: to_be_flushed=1, caused_by_i1=1, new_pc=32'hbfc00380, stallreq_mem=0, fetch_ready=1.
  - T: flush=4'b0111, kill_i2=1.
  - T+1: redirect_valid=1, redirect_pc=bfc00380, flush=4'b1111.
  - T+2: IDLE, flush=0.
- Slot-2 fault with drain:
  - Stimulus: caused_by_i2=1 only, stallreq_mem=1 for 3 cycles.
  - T: kill_i2=0.
  - DRAIN holds for 3 cycles with redirect_valid=0.
  - redirect_valid rises at T+4.
- Fetch backpressure:
  - Stimulus: fetch_ready=0 for 5 cycles in REDIRECT.
  - redirect_valid and redirect_pc stay constant for those 5 cycles.
  - Handshake completes on the 6th cycle.
- Second event while busy:
  - Stimulus: to_be_flushed=1 with new_pc=32'h80000010 during REDIRECT.
  - redirect_pc keeps the first target.
  - exc_count increments only once.
- ERET:
  - Stimulus: to_be_flushed=1, neither caused_by set, new_pc=EPC=32'h80001234.
  - kill_i2=0, redirect_pc=80001234.
- Reset in DRAIN:
  - Stimulus: rst=1 for 1 cycle while in DRAIN.
  - Next cycle: IDLE, flush=0, redirect_pc=RESET_PC, exc_count=0 (with REDIRECT_CNT_EN).

Source files
------------

// File: rtl/except_redirect_if.sv
// Signal bundle between CP0/pipeline/IF and the exception redirect controller.
// The slave modport is the controller; the master modport is its environment.
interface except_redirect_if;
  logic        to_be_flushed;
  logic [31:0] new_pc;
  logic        caused_by_i1;
  logic        caused_by_i2;
  logic        stallreq_mem;
  logic        fetch_ready;
  logic [3:0]  flush;
  logic        kill_i2;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;
  logic [31:0] exc_count;
  logic [1:0]  dbg_state;

  // Handshake: redirect_valid/redirect_pc hold steady until a cycle with
  // fetch_ready=1; the redirect is consumed at that clock edge.
  modport master (
    output to_be_flushed, new_pc, caused_by_i1, caused_by_i2,
    output stallreq_mem, fetch_ready,
    input  flush, kill_i2, redirect_valid, redirect_pc, busy, exc_count, dbg_state
  );

  modport slave (
    input  to_be_flushed, new_pc, caused_by_i1, caused_by_i2,
    input  stallreq_mem, fetch_ready,
    output flush, kill_i2, redirect_valid, redirect_pc, busy, exc_count, dbg_state
  );
endinterface

// File: rtl/except_redirect.sv
// Exception/ERET redirect controller: flushes the pipe, drains memory, then
// holds a PC redirect until IF accepts it. Optional counter: REDIRECT_CNT_EN.
module except_redirect #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic              clk,
  input  logic              rst,
  except_redirect_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRAIN    = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_redirect_pc;
  logic        r_redirect_valid;
  logic        r_busy;
  logic        w_event;

  assign w_event = (r_state == S_IDLE) && bus.to_be_flushed;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_redirect_pc    <= RESET_PC;
      r_redirect_valid <= 1'b0;
      r_busy           <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.to_be_flushed) begin
            r_redirect_pc <= bus.new_pc;
            r_busy        <= 1'b1;
            if (bus.stallreq_mem) begin
              r_state          <= S_DRAIN;
              r_redirect_valid <= 1'b0;
            end else begin
              r_state          <= S_REDIRECT;
              r_redirect_valid <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // An in-flight bus transaction must complete before IF moves on.
          if (!bus.stallreq_mem) begin
            r_state          <= S_REDIRECT;
            r_redirect_valid <= 1'b1;
          end
        end
        S_REDIRECT: begin
          if (bus.fetch_ready) begin
            r_state          <= S_IDLE;
            r_redirect_valid <= 1'b0;
            r_busy           <= 1'b0;
          end
        end
        default: begin
          r_state          <= S_IDLE;
          r_redirect_valid <= 1'b0;
          r_busy           <= 1'b0;
        end
      endcase
    end
  end

  // MEM/WB survives the event cycle so the faulting bundle's older work retires.
  assign bus.flush          = r_busy ? 4'b1111 : (w_event ? 4'b0111 : 4'b0000);
  assign bus.kill_i2        = w_event && bus.caused_by_i1;
  assign bus.redirect_valid = r_redirect_valid;
  assign bus.redirect_pc    = r_redirect_pc;
  assign bus.busy           = r_busy;
  assign bus.dbg_state      = r_state;

`ifdef REDIRECT_CNT_EN
  logic [31:0] r_exc_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_exc_count <= 32'd0;
    end else if (w_event) begin
      r_exc_count <= r_exc_count + 32'd1;
    end
  end

  assign bus.exc_count = r_exc_count;
`else
  assign bus.exc_count = 32'd0;
`endif

endmodule

// File: tb/tb_except_redirect.sv
// Bench for except_redirect: directed scenarios followed by random traffic,
// checked per cycle against a transaction-level model plus a PC scoreboard.
module tb_except_redirect;
  localparam logic [31:0] RST_PC = 32'hbfc00000;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] exp_q[$];

  except_redirect_if bus();

  except_redirect #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: is an exception being serviced, has the redirect been
  // offered to IF yet, which PC is owed, and how many events were taken.
  bit          m_in_service = 1'b0;
  bit          m_offered    = 1'b0;
  logic [31:0] m_pc         = RST_PC;
  logic [31:0] m_cnt        = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive, check combinational view at negedge, advance model at posedge.
  task automatic cycle(input bit tbf, input logic [31:0] pc, input bit i1, input bit i2,
                       input bit stall, input bit fr, input bit r = 1'b0);
    bit accepted;
    logic [3:0] e_flush;
    bus.to_be_flushed = tbf;
    bus.new_pc        = pc;
    bus.caused_by_i1  = i1;
    bus.caused_by_i2  = i2;
    bus.stallreq_mem  = stall;
    bus.fetch_ready   = fr;
    rst               = r;
    @(negedge clk);
    accepted = !m_in_service && tbf;
    if (m_in_service)  e_flush = 4'b1111;
    else if (accepted) e_flush = 4'b0111;
    else               e_flush = 4'b0000;
    chk("flush", {28'd0, bus.flush}, {28'd0, e_flush});
    chk("kill_i2", {31'd0, bus.kill_i2}, {31'd0, accepted && i1});
    chk("redirect_valid", {31'd0, bus.redirect_valid}, {31'd0, m_offered});
    chk("busy", {31'd0, bus.busy}, {31'd0, m_in_service});
    chk("redirect_pc", bus.redirect_pc, m_pc);
`ifdef REDIRECT_CNT_EN
    chk("exc_count", bus.exc_count, m_cnt);
`else
    chk("exc_count", bus.exc_count, 32'd0);
`endif
    @(posedge clk);
    if (r) begin
      m_in_service = 1'b0;
      m_offered    = 1'b0;
      m_pc         = RST_PC;
      m_cnt        = 32'd0;
      exp_q.delete();
    end else if (accepted) begin
      m_in_service = 1'b1;
      m_offered    = !stall;
      m_pc         = pc;
      m_cnt        = m_cnt + 32'd1;
      exp_q.push_back(pc);
    end else if (m_in_service && !m_offered) begin
      if (!stall) m_offered = 1'b1;
    end else if (m_offered && fr) begin
      m_in_service = 1'b0;
      m_offered    = 1'b0;
    end
    #1;
  endtask

  task automatic idle(input int n, input bit fr = 1'b1);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, fr);
  endtask

  // Monitor: every accepted redirect must match the oldest owed target.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.redirect_valid === 1'b1 && bus.fetch_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("redirect_unexpected", bus.redirect_pc, 32'hxxxxxxxx);
      end else begin
        chk("redirect_target", bus.redirect_pc, exp_q.pop_front());
      end
    end
  end

  initial begin
    bus.to_be_flushed = 1'b0;
    bus.new_pc        = 32'h0;
    bus.caused_by_i1  = 1'b0;
    bus.caused_by_i2  = 1'b0;
    bus.stallreq_mem  = 1'b0;
    bus.fetch_ready   = 1'b0;
    rst               = 1'b1;
    @(posedge clk);
    #1;
    cycle(0, 32'h0, 0, 0, 0, 0, 1'b1);
    idle(2);

    // Slot-1 fault, no drain.
    cycle(1, 32'hbfc00380, 1, 0, 0, 1);
    cycle(0, 32'h0, 0, 0, 0, 1);
    idle(2);

    // Slot-2 fault with a 3-cycle drain.
    cycle(1, 32'h80000200, 0, 1, 1, 1);
    cycle(0, 32'h0, 0, 0, 1, 1);
    cycle(0, 32'h0, 0, 0, 1, 1);
    cycle(0, 32'h0, 0, 0, 0, 0);
    cycle(0, 32'h0, 0, 0, 0, 1);
    idle(1);

    // Fetch backpressure with a second event arriving mid-redirect.
    cycle(1, 32'h80000180, 1, 1, 0, 0);
    cycle(0, 32'h0, 0, 0, 0, 0);
    cycle(1, 32'h80000010, 1, 0, 0, 0);
    cycle(0, 32'h0, 0, 0, 0, 0);
    cycle(1, 32'h80000010, 0, 1, 1, 0);
    cycle(0, 32'h0, 0, 0, 0, 0);
    cycle(0, 32'h0, 0, 0, 0, 1);
    // Back-to-back event on the first IDLE cycle.
    cycle(1, 32'h80001234, 0, 0, 0, 1);
    idle(2);

    // ERET-like event with a stall and fetch_ready pulsing during drain.
    cycle(1, 32'h80001234, 0, 0, 1, 1);
    cycle(0, 32'h0, 0, 0, 1, 1);
    cycle(0, 32'h0, 0, 0, 0, 1);
    idle(2);

    // Reset while draining.
    cycle(1, 32'h8000abcd, 1, 0, 1, 0);
    cycle(0, 32'h0, 0, 0, 1, 0, 1'b1);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
    end

    idle(8);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
